// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard-scoreboard definitions: producer latencies and the
// default largest accepted latency.
package hazard_scoreboard_pkg;

  localparam int LAT_ALU    = 1;
  localparam int LAT_LOAD   = 2;
  localparam int LAT_MUL    = 4;
  localparam int MAXLAT_DEF = 7;

  function automatic int unsigned lat_max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's latency countdown: decrements toward zero and, on an
// issue, loads the larger of the decremented value and the new latency.
module hazard_scoreboard_entry #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] lat,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] dec;

  always_comb begin
    dec   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    cnt_d = dec;
    // a younger short op never shortens an older long op's wait
    if (ld && (lat > dec)) cnt_d = lat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   cnt_q <= '0;
    else if (en) cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard deciding ID-stage stalls from per-register
// producer countdowns, with a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int MAXLAT = MAXLAT_DEF,
  parameter int CW     = 3,
  parameter int SCW    = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            hold,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_is_branch,
  input  logic            id_kill,
  input  logic            issue_valid,
  input  logic            issue_regwrite,
  input  logic [AW-1:0]   issue_rd,
  input  logic [CW-1:0]   issue_lat,
  input  logic            stat_clr,
  output logic            stall,
  output logic [NREG-1:0] pending,
  output logic [SCW-1:0]  stall_count
);

  logic [CW-1:0]  cnt [NREG];
  logic [CW-1:0]  thr;
  logic [CW-1:0]  lat_c;
  logic           need1;
  logic           need2;
  logic           iss;
  logic [SCW-1:0] sc_q;
  logic [SCW-1:0] sc_d;

  // branches resolve in ID so they also wait out the final cycle
  assign thr   = CW'(!id_is_branch);
  assign lat_c = (issue_lat > CW'(MAXLAT)) ? CW'(MAXLAT) : issue_lat;

  assign need1 = id_use_rs1 && (id_rs1 != '0) && (cnt[id_rs1] > thr);
  assign need2 = id_use_rs2 && (id_rs2 != '0) && (cnt[id_rs2] > thr);
  assign stall = issue_valid && !id_kill && (need1 || need2);

  assign iss = issue_valid && issue_regwrite && !stall && !id_kill &&
               !hold && (issue_rd != '0) && (issue_lat != '0);

  for (genvar r = 0; r < NREG; r++) begin : g_ent
    if (r == 0) begin : g_zero
      assign cnt[r] = '0;
    end else begin : g_reg
      hazard_scoreboard_entry #(.CW(CW)) u_ent (
        .clk  (clk),
        .rstn (rstn),
        .en   (!hold),
        .ld   (iss && (issue_rd == AW'(r))),
        .lat  (lat_c),
        .cnt  (cnt[r])
      );
    end
    assign pending[r] = (cnt[r] != '0);
  end

  always_comb begin
    sc_d = sc_q;
    if (stat_clr)                 sc_d = '0;
    else if (stall && !(&sc_q))   sc_d = sc_q + SCW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      sc_q <= '0;
    else if (!hold) sc_q <= sc_d;
  end

  assign stall_count = sc_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios, then random
// traffic checked against a ready-time model through a scoreboard queue.
module tb_hazard_scoreboard;

  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int MAXLAT = 7;
  localparam int CW     = 3;
  localparam int SCW    = 3;
  localparam int SCMAX  = (1 << SCW) - 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic            hold;
  logic [AW-1:0]   id_rs1, id_rs2;
  logic            id_use_rs1, id_use_rs2;
  logic            id_is_branch, id_kill;
  logic            issue_valid, issue_regwrite;
  logic [AW-1:0]   issue_rd;
  logic [CW-1:0]   issue_lat;
  logic            stat_clr;
  logic            stall;
  logic [NREG-1:0] pending;
  logic [SCW-1:0]  stall_count;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG(NREG), .AW(AW), .MAXLAT(MAXLAT), .CW(CW), .SCW(SCW)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .hold           (hold),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_is_branch   (id_is_branch),
    .id_kill        (id_kill),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_rd       (issue_rd),
    .issue_lat      (issue_lat),
    .stat_clr       (stat_clr),
    .stall          (stall),
    .pending        (pending),
    .stall_count    (stall_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            stall;
    logic [NREG-1:0] pend;
    int              sc;
  } exp_t;

  exp_t q[$];

  always @(posedge clk)
    if (rstn === 1'b1)
      assert (issue_lat <= MAXLAT);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    hold = 0; stat_clr = 0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_branch = 0; id_kill = 0;
    issue_valid = 0; issue_regwrite = 0; issue_rd = '0; issue_lat = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    idle();
    repeat (8) step();
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    repeat (2) step();
    rstn = 1;
    step();
  endtask

  task automatic issue_prod(int rd, int lat);
    idle();
    issue_valid = 1; issue_regwrite = 1;
    issue_rd = AW'(rd); issue_lat = CW'(lat);
    step();
  endtask

  task automatic consumer(int rs, bit br);
    idle();
    issue_valid = 1; id_use_rs1 = 1; id_rs1 = AW'(rs); id_is_branch = br;
    #1;
  endtask

  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (!stall) break;
      n++;
      step();
    end
  endtask

  task automatic dep_test(string name, int lat, bit br, int exp_n);
    int n;
    issue_prod(7, lat);
    consumer(7, br);
    count_stalls(n);
    chk(name, n, exp_n);
    drain();
  endtask

  // model: absolute ready tick per register, tick advances on non-hold edges
  longint ready_at [NREG];
  longint tick;
  int     sc_m;

  function automatic longint rem(int r);
    if (r == 0) return 0;
    return (ready_at[r] > tick) ? ready_at[r] - tick : 0;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rnd_stall", stall, e.stall);
      chk("rnd_pending", pending, e.pend);
      chk("rnd_stall_count", stall_count, e.sc);
    end
  end

  initial begin
    int   n;
    int   sc0;
    exp_t e;
    bit   nd1, nd2, iss;
    longint thr;

    do_reset();
    chk("reset_stall", stall, 0);
    chk("reset_pending", pending, 0);
    chk("reset_count", stall_count, 0);

    issue_prod(5, 2);
    chk("load_pending5", pending[5], 1);
    idle();
    issue_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    issue_regwrite = 1; issue_rd = 6; issue_lat = 1;
    #1;
    count_stalls(n);
    chk("load_add_stalls", n, 1);
    step();
    chk("load_add_count", stall_count, 1);
    chk("load_add_pend6", pending[6], 1);
    drain();

    dep_test("alu_branch", 1, 1, 1);
    dep_test("load_branch", 2, 1, 2);
    dep_test("alu_ex", 1, 0, 0);
    dep_test("load_ex", 2, 0, 1);

    issue_prod(9, 5);
    issue_prod(9, 1);
    chk("waw_pending9", pending[9], 1);
    consumer(9, 0);
    count_stalls(n);
    chk("waw_stalls", n, 3);
    drain();

    issue_prod(5, 2);
    consumer(5, 0);
    chk("hold_stall_on", stall, 1);
    sc0 = int'(stall_count);
    hold = 1;
    repeat (3) step();
    chk("hold_count_frozen", stall_count, sc0);
    chk("hold_stall_still", stall, 1);
    hold = 0;
    #1;
    count_stalls(n);
    chk("hold_cnt_kept", n, 1);
    drain();

    issue_prod(5, 2);
    idle();
    issue_valid = 1; id_use_rs1 = 1; id_rs1 = 5; id_kill = 1;
    issue_regwrite = 1; issue_rd = 10; issue_lat = 3;
    #1;
    chk("kill_stall", stall, 0);
    step();
    chk("kill_no_load", pending[10], 0);
    drain();

    idle(); stat_clr = 1; step();
    chk("clr_count", stall_count, 0);
    dep_test("mul7_ex", 7, 0, 6);
    dep_test("mul5_ex", 5, 0, 4);
    chk("sat_count", stall_count, SCMAX);
    issue_prod(5, 2);
    consumer(5, 0);
    chk("clr_stall_on", stall, 1);
    stat_clr = 1;
    step();
    chk("clr_with_stall", stall_count, 0);
    drain();

    issue_prod(0, 3);
    chk("x0_pending", pending, 0);
    idle();
    issue_valid = 1; id_use_rs1 = 1; id_use_rs2 = 1;
    #1;
    chk("x0_stall", stall, 0);
    drain();

    issue_prod(5, 2);
    consumer(5, 0);
    rstn = 0;
    #1;
    chk("async_rst_pending", pending, 0);
    chk("async_rst_stall", stall, 0);
    step();
    rstn = 1;
    idle();
    step();

    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    tick = 0;
    sc_m = 0;
    for (int c = 0; c < 3000; c++) begin
      hold           = ($urandom_range(0, 5) == 0);
      stat_clr       = ($urandom_range(0, 15) == 0);
      id_rs1         = AW'($urandom_range(0, 7));
      id_rs2         = AW'($urandom_range(0, 7));
      id_use_rs1     = $urandom_range(0, 1);
      id_use_rs2     = $urandom_range(0, 1);
      id_is_branch   = ($urandom_range(0, 3) == 0);
      id_kill        = ($urandom_range(0, 9) == 0);
      issue_valid    = ($urandom_range(0, 4) != 0);
      issue_regwrite = $urandom_range(0, 1);
      issue_rd       = AW'($urandom_range(0, 7));
      issue_lat      = CW'($urandom_range(0, MAXLAT));
      thr = id_is_branch ? 0 : 1;
      nd1 = id_use_rs1 && rem(int'(id_rs1)) > thr;
      nd2 = id_use_rs2 && rem(int'(id_rs2)) > thr;
      e.stall = issue_valid && !id_kill && (nd1 || nd2);
      for (int r = 0; r < NREG; r++) e.pend[r] = (rem(r) != 0);
      e.sc = sc_m;
      q.push_back(e);
      @(posedge clk);
      if (!hold) begin
        iss = issue_valid && issue_regwrite && !e.stall && !id_kill &&
              issue_rd != 0 && issue_lat != 0;
        if (iss && ready_at[issue_rd] < tick + 1 + issue_lat)
          ready_at[issue_rd] = tick + 1 + issue_lat;
        tick++;
        if (stat_clr) sc_m = 0;
        else if (e.stall && sc_m < SCMAX) sc_m++;
      end
      #1;
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the per-stage hazard comparator: a register scoreboard holding a per-register latency countdown instead of comparing fixed ID/EX and EX/MEM fields.
- Supports producers of arbitrary latency (ALU, load, multi-cycle MUL/DIV) and decides ID-stage stalls for both EX-consumers and ID-resolved branches.
- Sits beside the decode stage, is fed by the ID→EX issue point, and drives the IF/ID hold and the ID/EX bubble.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired zero.
AW, 5, register index width; equals clog2(NREG).
MAXLAT, 7, largest producer latency accepted.
CW, 3, countdown width; equals clog2(MAXLAT+1).
SCW, 16, stall-counter width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rstn  in  1  reset, asynchronous assertion, active-low.
hold  in  1  global pipeline freeze (e.g. memory wait); scoreboard state and stall counter are frozen.
id_rs1  in  AW  source 1 of the instruction in ID.
id_rs2  in  AW  source 2 of the instruction in ID.
id_use_rs1  in  1  instruction in ID reads rs1.
id_use_rs2  in  1  instruction in ID reads rs2.
id_is_branch  in  1  instruction in ID is a branch resolved in ID.
id_kill  in  1  instruction in ID is squashed (flush); it must not issue.
issue_valid  in  1  instruction in ID is valid and would enter EX this edge.
issue_regwrite  in  1  that instruction writes a register.
issue_rd  in  AW  its destination.
issue_lat  in  CW  cycles until its result leaves its final execute stage: ALU=1, load=2, MUL=up to MAXLAT.
stat_clr  in  1  synchronous clear of stall_count.
stall  out  1  hold IF/ID and PC, insert bubble into ID/EX.
pending  out  NREG  bit r is 1 when cnt[r] != 0.
stall_count  out  SCW  saturating count of cycles with stall=1 and hold=0.

Behaviour:
State:
- cnt[r], CW bits, for r = 1..NREG-1. cnt[0] does not exist and reads as 0.
- stall_count.

Reset (rstn=0, asynchronous):
- All cnt = 0 and stall_count = 0.
- Therefore pending = 0 and stall = 0 while in reset.

Stall, combinational from the current cnt:
- need_k = id_use_rsk && id_rsk != 0 && cnt[id_rsk] > thr, where thr = 0 if id_is_branch, else 1.
- stall = issue_valid && !id_kill && (need_1 || need_2).
- stall is independent of hold.
- Resulting stall windows:
  - ALU→EX-consumer: 0 cycles.
  - Load→EX-consumer: 1 cycle.
  - ALU→branch: 1 cycle.
  - Load→branch: 2 cycles.
  - Latency-L→EX-consumer: L-1 cycles.

Issue qualification:
- iss = issue_valid && issue_regwrite && !stall && !id_kill && !hold && issue_rd != 0 && issue_lat != 0.

Update per edge, only when hold = 0:
- dec[r] = cnt[r] - 1 if cnt[r] != 0, else 0.
- cnt[r] <= dec[r] for every r except the issue target.
- If iss: cnt[issue_rd] <= max(dec[issue_rd], issue_lat). This covers WAW: a younger short op never shortens an older long op's wait.

Edge cases:
- issue_lat > MAXLAT is illegal; the bench asserts it never occurs.
- hold = 1: no decrement, no issue, stall_count unchanged.
- A consumer whose source is issue_rd in the same cycle sees the old cnt. This is correct because that producer is the instruction itself.
- id_kill forces stall = 0 in the same cycle and blocks the issue.

stall_count, on each edge with hold = 0:
- stat_clr has priority and loads 0.
- Otherwise, if stall = 1 and stall_count is not all-ones, increment; it saturates at all-ones.

Decomposition:
- Shared package/include ctrl_encode_def.v gains:
  - LAT_ALU = 1, LAT_LOAD = 2, LAT_MUL = 4.
  - The default MAXLAT.
- One natural sub-module, hazard_scoreboard_entry: a single countdown register with dec/load-max logic, instantiated by generate for r = 1..NREG-1.

Test Plan:
- Reset mid-operation: cnt[5] = 2, then rstn low → pending = 0 and stall = 0 immediately, before any clock edge.
- Load then ALU: load x5 (lat 2), next instruction add x6,x5 → stall for exactly 1 cycle, then issue; stall_count = 1.
- ALU then branch: add x7 (lat 1), next beq x7,x0 → 1 stall. Load x7 then beq → 2 stalls. Same two sequences with a non-branch consumer → 0 and 1 stalls.
- Multi-cycle and WAW: mul x9 (lat 5), then add x9 (lat 1) → cnt[9] stays at 4 after the second issue; a consumer of x9 stalls until cnt[9] <= 1 (3 stall cycles after the add).
- Hold and kill: while stalling on x5 with cnt = 2, hold = 1 for 3 cycles → cnt stays 2 and stall_count is frozen. Kill asserted with a dependency → stall = 0 and no cnt load.
- Saturation and clear: SCW = 2, 5 stall cycles → stall_count = 3. stat_clr together with stall → 0. Source x0 with pending writes to x0 → no stall, pending[0] = 0.
